uart_tx_cfg: RTL and testbench

Runtime-configurable UART transmitter, the successor to the fixed-format 8N1 transmitter. It serialises one word per ready/valid handshake. Data length, parity and stop length are selectable per frame; the oversampling ratio is a parameter. It sits between the TX FIFO/host interface and the pad, and is paced by the shared baud-rate generator's s_tick.

---
 rtl/uart_pkg.sv | 49 ++++
 rtl/uart_bit_timer.sv | 32 +++
 rtl/uart_tx_cfg.sv | 183 ++++++++++++++++++
 tb/tb_uart_tx_cfg.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and helpers for the configurable UART transmitter and its bit timer.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    PAR_NONE = 2'd0,
    PAR_EVEN = 2'd1,
    PAR_ODD  = 2'd2
  } par_e;

  typedef enum logic [1:0] {
    STOP_1   = 2'd0,
    STOP_1P5 = 2'd1,
    STOP_2   = 2'd2
  } stop_e;

  // 2'b11 is an alias for "no parity".
  function automatic par_e par_decode(input logic [1:0] code);
    case (code)
      2'b01:   return PAR_EVEN;
      2'b10:   return PAR_ODD;
      default: return PAR_NONE;
    endcase
  endfunction

  function automatic stop_e stop_decode(input logic [1:0] code);
    case (code)
      2'b00:   return STOP_1;
      2'b01:   return STOP_1P5;
      default: return STOP_2;
    endcase
  endfunction

  function automatic int unsigned stop_ticks(input int unsigned ovs, input stop_e stop);
    case (stop)
      STOP_1:   return ovs;
      STOP_1P5: return ovs + ovs / 2;
      default:  return 2 * ovs;
    endcase
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Counts s_tick strobes up to a runtime limit and flags the tick that ends the interval.
module uart_bit_timer #(
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             s_tick,
  input  logic             en,
  input  logic             clr,
  input  logic [CNT_W-1:0] limit,
  output logic             bit_end
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // A clear wins over a coincident tick, so the tick in a restart cycle is dropped.
  assign bit_end = en && !clr && s_tick && (cnt_q == limit - CNT_W'(1));

  always_comb begin
    cnt_d = cnt_q;
    if (clr)
      cnt_d = '0;
    else if (en && s_tick)
      cnt_d = bit_end ? '0 : cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/uart_tx_cfg.sv
// Runtime-configurable UART transmitter (5..DBIT_MAX data bits, none/even/odd parity, 1/1.5/2 stop).
// Optional line-break generation is compiled in with UART_TX_BREAK_EN.
module uart_tx_cfg
  import uart_pkg::*;
#(
  parameter int DBIT_MAX = 8,
  parameter int OVS      = 16
) (
  input  logic                            clk,
  input  logic                            reset_n,
`ifdef UART_TX_BREAK_EN
  input  logic                            tx_break,
`endif
  input  logic                            s_tick,
  input  logic                            tx_valid,
  output logic                            tx_ready,
  input  logic [DBIT_MAX-1:0]             din,
  input  logic [$clog2(DBIT_MAX+1)-1:0]   cfg_nbits,
  input  logic [1:0]                      cfg_par,
  input  logic [1:0]                      cfg_stop,
  output logic                            tx_done_tick,
  output logic                            tx_busy,
  output logic                            tx
);

  localparam int NB_W  = $clog2(DBIT_MAX + 1);
  localparam int CNT_W = $clog2(2 * OVS + 1);

  state_e               state_q, state_d;
  logic                 tx_q, tx_d;
  logic [NB_W-1:0]      bitcnt_q, bitcnt_d;
  logic [DBIT_MAX-1:0]  shift_q, shift_d;
  logic [NB_W-1:0]      nbits_q, nbits_d;
  par_e                 par_q, par_d;
  stop_e                stop_q, stop_d;
  logic                 pacc_q, pacc_d;
  logic                 accept, done;
  logic                 tmr_en, tmr_clr, bit_end;
  logic [CNT_W-1:0]     tmr_limit;
`ifdef UART_TX_BREAK_EN
  logic                 guard_q, guard_d;
`endif

  function automatic logic [NB_W-1:0] clamp_nbits(input logic [NB_W-1:0] n);
    if (n < NB_W'(5))        return NB_W'(5);
    if (n > NB_W'(DBIT_MAX)) return NB_W'(DBIT_MAX);
    return n;
  endfunction

`ifdef UART_TX_BREAK_EN
  assign tx_ready = (state_q == IDLE) && !tx_break && !guard_q;
`else
  assign tx_ready = (state_q == IDLE);
`endif
  assign accept       = tx_valid && tx_ready;
  assign tx_busy      = (state_q != IDLE);
  assign tx           = tx_q;
  assign tx_done_tick = done;

  always_comb begin
    tmr_en    = (state_q != IDLE);
    tmr_clr   = accept;
    tmr_limit = CNT_W'(OVS);
    if (state_q == STOP) tmr_limit = CNT_W'(stop_ticks(OVS, stop_q));
`ifdef UART_TX_BREAK_EN
    // In IDLE the timer measures the mark-after-break guard instead.
    if (state_q == IDLE) begin
      tmr_en  = guard_q && !tx_break;
      tmr_clr = accept || tx_break;
    end
`endif
  end

  uart_bit_timer #(.CNT_W(CNT_W)) u_timer (
    .clk    (clk),
    .rst_n  (reset_n),
    .s_tick (s_tick),
    .en     (tmr_en),
    .clr    (tmr_clr),
    .limit  (tmr_limit),
    .bit_end(bit_end)
  );

  // tx_d always carries the line level of the state being entered.
  always_comb begin
    state_d  = state_q;
    tx_d     = tx_q;
    bitcnt_d = bitcnt_q;
    shift_d  = shift_q;
    nbits_d  = nbits_q;
    par_d    = par_q;
    stop_d   = stop_q;
    pacc_d   = pacc_q;
    done     = 1'b0;
`ifdef UART_TX_BREAK_EN
    guard_d  = guard_q;
`endif
    case (state_q)
      IDLE: begin
        tx_d = 1'b1;
`ifdef UART_TX_BREAK_EN
        if (tx_break) begin
          tx_d    = 1'b0;
          guard_d = 1'b1;
        end else if (guard_q && bit_end) begin
          guard_d = 1'b0;
        end
`endif
        if (accept) begin
          state_d  = START;
          tx_d     = 1'b0;
          shift_d  = din;
          nbits_d  = clamp_nbits(cfg_nbits);
          par_d    = par_decode(cfg_par);
          stop_d   = stop_decode(cfg_stop);
          bitcnt_d = '0;
          pacc_d   = 1'b0;
        end
      end
      START: if (bit_end) begin
        state_d = DATA;
        tx_d    = shift_q[0];
      end
      DATA: if (bit_end) begin
        shift_d  = shift_q >> 1;
        bitcnt_d = bitcnt_q + NB_W'(1);
        pacc_d   = pacc_q ^ shift_q[0];
        if (bitcnt_q == nbits_q - NB_W'(1)) begin
          if (par_q != PAR_NONE) begin
            state_d = PARITY;
            tx_d    = pacc_d ^ (par_q == PAR_ODD);
          end else begin
            state_d = STOP;
            tx_d    = 1'b1;
          end
        end else begin
          tx_d = shift_d[0];
        end
      end
      PARITY: if (bit_end) begin
        state_d = STOP;
        tx_d    = 1'b1;
      end
      STOP: if (bit_end) begin
        state_d = IDLE;
        tx_d    = 1'b1;
        done    = 1'b1;
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      tx_q     <= 1'b1;
      bitcnt_q <= '0;
`ifdef UART_TX_BREAK_EN
      guard_q  <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      tx_q     <= tx_d;
      bitcnt_q <= bitcnt_d;
`ifdef UART_TX_BREAK_EN
      guard_q  <= guard_d;
`endif
    end
  end

  // Frame shadows are only read after an accept has loaded them.
  always_ff @(posedge clk) begin
    shift_q <= shift_d;
    nbits_q <= nbits_d;
    par_q   <= par_d;
    stop_q  <= stop_d;
    pacc_q  <= pacc_d;
  end

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Randomized bench for uart_tx_cfg against a per-tick line-level reference model.
module tb_uart_tx_cfg;

  localparam int DBIT_MAX = 8;
  localparam int OVS      = 16;

  typedef struct {
    logic [7:0] data;
    logic [3:0] nb;
    logic [1:0] par;
    logic [1:0] stop;
  } word_t;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       s_tick;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] din;
  logic [3:0] cfg_nbits;
  logic [1:0] cfg_par;
  logic [1:0] cfg_stop;
  logic       tx_done_tick;
  logic       tx_busy;
  logic       tx;

  int    n_chk  = 0;
  int    n_pass = 0;
  word_t pend[$];
  bit    exp_q[$];
  bit    act    = 1'b0;
  int    j      = 0;
  int    cyc    = 0;
  int    done_cyc = -100;
  int    acc_gap  = 0;
  int    last_len = 0;
  int    tick_mode = 0;
  bit    hold_valid = 1'b1;

  uart_tx_cfg #(.DBIT_MAX(DBIT_MAX), .OVS(OVS)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
`ifdef UART_TX_BREAK_EN
    .tx_break    (1'b0),
`endif
    .s_tick      (s_tick),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .din         (din),
    .cfg_nbits   (cfg_nbits),
    .cfg_par     (cfg_par),
    .cfg_stop    (cfg_stop),
    .tx_done_tick(tx_done_tick),
    .tx_busy     (tx_busy),
    .tx          (tx)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, obs, exp, cyc);
  endtask

  // Expected line level for each tick slot of one frame, from the frame format rules.
  task automatic build_frame(input logic [7:0] d, input logic [3:0] nb,
                             input logic [1:0] par, input logic [1:0] st);
    int n;
    bit p;
    n = (nb < 5) ? 5 : ((nb > DBIT_MAX) ? DBIT_MAX : int'(nb));
    p = 1'b0;
    exp_q.delete();
    repeat (OVS) exp_q.push_back(1'b0);
    for (int i = 0; i < n; i++) begin
      p ^= d[i];
      repeat (OVS) exp_q.push_back(d[i]);
    end
    if (par == 2'b01) repeat (OVS) exp_q.push_back(p);
    else if (par == 2'b10) repeat (OVS) exp_q.push_back(!p);
    repeat ((st == 2'b00) ? OVS : ((st == 2'b01) ? OVS * 3 / 2 : 2 * OVS)) exp_q.push_back(1'b1);
  endtask

  task automatic step();
    bit acc;
    @(negedge clk);
    cyc++;
    chk("tx", tx, act ? exp_q[j] : 1'b1);
    s_tick = (tick_mode == 0) ? 1'b1 : ($urandom_range(0, 2) == 0);
    if (pend.size() > 0 && (hold_valid || $urandom_range(0, 1) == 1)) begin
      tx_valid  = 1'b1;
      din       = pend[0].data;
      cfg_nbits = pend[0].nb;
      cfg_par   = pend[0].par;
      cfg_stop  = pend[0].stop;
    end else begin
      tx_valid  = 1'b0;
      din       = 8'($urandom);
      cfg_nbits = 4'($urandom);
      cfg_par   = 2'($urandom);
      cfg_stop  = 2'($urandom);
    end
    #1;
    chk("ready", tx_ready, !act);
    chk("busy", tx_busy, act);
    chk("done", tx_done_tick, act && s_tick && (j == exp_q.size() - 1));
    if (tx_done_tick) begin
      done_cyc = cyc;
      last_len = j + 1;
    end
    if (tx_ready && tx_valid) acc_gap = cyc - done_cyc;
    acc = !act && tx_valid;
    if (act && s_tick) begin
      j++;
      if (j == exp_q.size()) act = 1'b0;
    end
    if (acc) begin
      build_frame(din, cfg_nbits, cfg_par, cfg_stop);
      act = 1'b1;
      j   = 0;
      void'(pend.pop_front());
    end
  endtask

  task automatic run(input int max_cyc);
    int k;
    k = 0;
    while ((pend.size() > 0 || act) && k < max_cyc) begin
      step();
      k++;
    end
    chk("drain", pend.size() + int'(act), 0);
    repeat (2) step();
  endtask

  task automatic push(input logic [7:0] d, input logic [3:0] nb,
                      input logic [1:0] par, input logic [1:0] st);
    word_t w;
    w.data = d; w.nb = nb; w.par = par; w.stop = st;
    pend.push_back(w);
  endtask

  initial begin
    int k;
    reset_n = 1'b0; s_tick = 1'b0; tx_valid = 1'b0;
    din = '0; cfg_nbits = '0; cfg_par = '0; cfg_stop = '0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_tx", tx, 1'b1);
    chk("rst_ready", tx_ready, 1'b1);
    chk("rst_busy", tx_busy, 1'b0);
    chk("rst_done", tx_done_tick, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;

    tick_mode = 0; hold_valid = 1'b1;
    push(8'h55, 4'd8, 2'b00, 2'b00); run(1000); chk("len_8n1", last_len, 160);
    push(8'h83, 4'd7, 2'b01, 2'b00); run(1000); chk("len_7e1", last_len, 160);
    push(8'h1F, 4'd5, 2'b10, 2'b10); run(1000); chk("len_5o2", last_len, 144);
    push(8'h00, 4'd8, 2'b00, 2'b01); run(1000); chk("len_8n15", last_len, 168);

    push(8'hA5, 4'd8, 2'b00, 2'b00);
    push(8'h3C, 4'd8, 2'b00, 2'b00);
    run(2000);
    chk("b2b_gap", acc_gap, 1);

    // Abort in the middle of data bit 3.
    push(8'h5A, 4'd8, 2'b01, 2'b00);
    k = 0;
    while (!(act && j >= OVS * 4 + 5) && k < 1000) begin
      step();
      k++;
    end
    chk("abort_reached", int'(act), 1);
    @(negedge clk);
    reset_n = 1'b0; tx_valid = 1'b0;
    #1;
    chk("abort_tx", tx, 1'b1);
    chk("abort_done", tx_done_tick, 1'b0);
    chk("abort_ready", tx_ready, 1'b1);
    chk("abort_busy", tx_busy, 1'b0);
    act = 1'b0;
    pend.delete();
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (2) step();
    push(8'h12, 4'd8, 2'b00, 2'b00); run(1000); chk("len_after_abort", last_len, 160);

    tick_mode = 1; hold_valid = 1'b0;
    for (int i = 0; i < 30; i++)
      push(8'($urandom), 4'($urandom), 2'($urandom), 2'($urandom));
    run(60000);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
